// File: rtl/adsr_pkg.sv
// rtl/adsr_pkg.sv - shared types, constants and fixed-point helpers for the polyphonic ADSR
package adsr_pkg;

    localparam int FIXED_BITS = 32;
    localparam int FRAC_BITS  = 16;

    typedef logic signed [FIXED_BITS-1:0]   fixed;
    typedef logic signed [2*FIXED_BITS-1:0] mul_type;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } adsr_state_t;

    typedef struct packed {
        fixed a;
        fixed d;
        fixed s;
        fixed r;
    } patch_t;

    localparam fixed ONE   = fixed'(1 << FRAC_BITS);
    localparam fixed MAX_F = 32'sh7fff_ffff;

    // Curve-shape constants in Q16: -1.46633706879, -9.21044036698, log2(e)
    localparam fixed ALPHA_A = -32'sd96098;
    localparam fixed ALPHA_D = -32'sd603615;
    localparam fixed ALPHA_R = -32'sd603615;
    localparam fixed LOG2E   = 32'sd94548;

    function automatic fixed fmul(input fixed x, input fixed y);
        mul_type p;
        p = mul_type'(x) * mul_type'(y);
        return fixed'(p >>> FRAC_BITS);
    endfunction

endpackage

// File: rtl/adsr_coefs.sv
// rtl/adsr_coefs.sv - per-sweep curve coefficients and bases shared by all voices
module adsr_coefs
    import adsr_pkg::*;
#(
    parameter int  FRACTIONAL_BITS = 16,
    parameter real ATTACK_RATIO    = 0.3,
    parameter real DECAY_RATIO     = 0.0001,
    parameter real RELEASE_RATIO   = 0.0001
) (
    input  patch_t patch,
    output fixed   coef_a,
    output fixed   coef_d,
    output fixed   coef_r,
    output fixed   base_a,
    output fixed   base_d,
    output fixed   base_r
);

    localparam real  SCALE           = 2.0 ** FRACTIONAL_BITS;
    localparam fixed ATTACK_RATIO_F  = fixed'($rtoi(ATTACK_RATIO * SCALE));
    localparam fixed DECAY_RATIO_F   = fixed'($rtoi(DECAY_RATIO * SCALE));
    localparam fixed RELEASE_RATIO_F = fixed'($rtoi(RELEASE_RATIO * SCALE));

    fixed arg_a;
    fixed arg_d;
    fixed arg_r;

    assign arg_a = fmul(ALPHA_A, patch.a);
    assign arg_d = fmul(ALPHA_D, patch.d);
    assign arg_r = fmul(ALPHA_R, patch.r);

    eexp u_exp_a (.x(arg_a), .y(coef_a));
    eexp u_exp_d (.x(arg_d), .y(coef_d));
    eexp u_exp_r (.x(arg_r), .y(coef_r));

    assign base_a = fmul(ONE + ATTACK_RATIO_F, ONE - coef_a);
    assign base_d = fmul(patch.s - DECAY_RATIO_F, ONE - coef_d);
    assign base_r = fmul(fixed'(0) - RELEASE_RATIO_F, ONE - coef_r);

endmodule

// File: rtl/eexp.sv
// rtl/eexp.sv - combinational fixed-point e^x via 2^(x*log2e) with a quadratic fraction fit
module eexp
    import adsr_pkg::*;
(
    input  fixed x,
    output fixed y
);

    // 2^f ~= 1 + c1*f + c2*f^2, exact at f=0 and f=1
    localparam logic [31:0] EXP2_C1 = 32'd43012;
    localparam logic [31:0] EXP2_C2 = 32'd22524;

    fixed        t;
    fixed        k;
    fixed        nk;
    fixed        p;
    logic [31:0] fz;
    logic [31:0] f2;

    always_comb begin
        t  = fmul(x, LOG2E);
        k  = t >>> FRAC_BITS;
        nk = -k;
        fz = {{(32-FRAC_BITS){1'b0}}, t[FRAC_BITS-1:0]};
        f2 = (fz * fz) >> FRAC_BITS;
        p  = ONE + fixed'((fz * EXP2_C1) >> FRAC_BITS) + fixed'((f2 * EXP2_C2) >> FRAC_BITS);
        y  = '0;
        if (k >= 0) begin
            y = (k > 13) ? MAX_F : (p <<< k);
        end else if (nk <= 31) begin
            y = p >>> nk;
        end
    end

endmodule

// File: rtl/adsr_poly.sv
// rtl/adsr_poly.sv - time-multiplexed ADSR envelopes, one voice per clock per sample sweep
module adsr_poly
    import adsr_pkg::*;
#(
    parameter int  TOTAL_BITS      = 32,
    parameter int  FRACTIONAL_BITS = 16,
    parameter int  VOICES          = 8,
    parameter real ATTACK_RATIO    = 0.3,
    parameter real DECAY_RATIO     = 0.0001,
    parameter real RELEASE_RATIO   = 0.0001,
    localparam int VOICE_BITS      = $clog2(VOICES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_tick,
    input  logic signed [TOTAL_BITS-1:0] a,
    input  logic signed [TOTAL_BITS-1:0] d,
    input  logic signed [TOTAL_BITS-1:0] s,
    input  logic signed [TOTAL_BITS-1:0] r,
    input  logic                         retrig_mode,
    input  logic [VOICES-1:0]            gate,
    output logic                         out_valid,
    output logic [VOICE_BITS-1:0]        out_voice,
    output logic signed [TOTAL_BITS-1:0] out,
    output logic [VOICES-1:0]            active,
    output logic                         busy,
    output logic                         overrun
);

    patch_t                patch_q;
    logic                  retrig_q;
    logic [VOICE_BITS-1:0] slot;
    adsr_state_t           state_q [VOICES];
    fixed                  level_q [VOICES];
    logic [VOICES-1:0]     prev_q;

    fixed        coef_a, coef_d, coef_r;
    fixed        base_a, base_d, base_r;
    adsr_state_t cur_state, nxt_state;
    fixed        cur_level, nxt_level, n;
    logic        g, pv;

    adsr_coefs #(
        .FRACTIONAL_BITS(FRACTIONAL_BITS),
        .ATTACK_RATIO   (ATTACK_RATIO),
        .DECAY_RATIO    (DECAY_RATIO),
        .RELEASE_RATIO  (RELEASE_RATIO)
    ) u_coefs (
        .patch (patch_q),
        .coef_a(coef_a),
        .coef_d(coef_d),
        .coef_r(coef_r),
        .base_a(base_a),
        .base_d(base_d),
        .base_r(base_r)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            patch_q   <= '0;
            retrig_q  <= 1'b0;
            slot      <= '0;
            prev_q    <= '0;
            active    <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            out_valid <= 1'b0;
            out_voice <= '0;
            out       <= '0;
            for (int i = 0; i < VOICES; i++) begin
                state_q[i] <= IDLE;
                level_q[i] <= '0;
            end
        end else begin
            overrun   <= sample_tick && busy;
            out_valid <= busy;
            if (busy) begin
                state_q[slot] <= nxt_state;
                level_q[slot] <= nxt_level;
                prev_q[slot]  <= gate[slot];
                active[slot]  <= (nxt_state != IDLE);
                out_voice     <= slot;
                out           <= nxt_level;
                if (slot == VOICE_BITS'(VOICES - 1)) begin
                    busy <= 1'b0;
                end else begin
                    slot <= slot + 1'b1;
                end
            end
            if (sample_tick && !busy) begin
                busy     <= 1'b1;
                slot     <= '0;
                patch_q  <= '{a: a, d: d, s: s, r: r};
                retrig_q <= retrig_mode;
            end
        end
    end

    // Gate edges take priority over the curve step; the curve resumes next sweep
    always_comb begin
        cur_state = state_q[slot];
        cur_level = level_q[slot];
        g         = gate[slot];
        pv        = prev_q[slot];
        nxt_state = cur_state;
        nxt_level = cur_level;
        n         = '0;
        if (g && !pv) begin
            nxt_state = ATTACK;
            if (retrig_q) nxt_level = '0;
        end else if (!g && pv && cur_state != IDLE) begin
            nxt_state = RELEASE;
        end else begin
            case (cur_state)
                ATTACK: begin
                    n = base_a + fmul(cur_level, coef_a);
                    if (n >= ONE) begin
                        nxt_level = ONE;
                        nxt_state = DECAY;
                    end else begin
                        nxt_level = n;
                    end
                end
                DECAY: begin
                    n = base_d + fmul(cur_level, coef_d);
                    if (n <= patch_q.s) begin
                        nxt_level = patch_q.s;
                        nxt_state = SUSTAIN;
                    end else begin
                        nxt_level = n;
                    end
                end
                SUSTAIN: nxt_level = patch_q.s;
                RELEASE: begin
                    n = base_r + fmul(cur_level, coef_r);
                    if (n <= 0) begin
                        nxt_level = '0;
                        nxt_state = IDLE;
                    end else begin
                        nxt_level = n;
                    end
                end
                default: nxt_level = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_adsr_poly.sv
// tb/tb_adsr_poly.sv - scoreboard and vector-table bench for adsr_poly
module tb_adsr_poly;

    localparam int VOICES = 8;
    localparam int NV     = 19;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_tick;
    logic signed [31:0] a, d, s, r;
    logic               retrig_mode;
    logic [7:0]         gate;
    logic               out_valid;
    logic [2:0]         out_voice;
    logic signed [31:0] out;
    logic [7:0]         active;
    logic               busy;
    logic               overrun;

    adsr_poly #(.VOICES(VOICES)) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_tick(sample_tick),
        .a          (a),
        .d          (d),
        .s          (s),
        .r          (r),
        .retrig_mode(retrig_mode),
        .gate       (gate),
        .out_valid  (out_valid),
        .out_voice  (out_voice),
        .out        (out),
        .active     (active),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]         voice;
        logic signed [31:0] level;
    } exp_t;

    typedef struct {
        logic [7:0]         gate;
        logic signed [31:0] s;
        logic               retrig;
        logic [7:0]         act;
        logic signed [31:0] lv0;
        logic signed [31:0] lv2;
        logic signed [31:0] lvx;
    } vec_t;

    exp_t exp_q[$];
    vec_t vec[NV];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic push_sweep(input logic signed [31:0] lv0, input logic signed [31:0] lv2,
                              input logic signed [31:0] lvx);
        for (int k = 0; k < VOICES; k++) begin
            exp_t e;
            e.voice = 3'(k);
            e.level = (k == 0) ? lv0 : (k == 2) ? lv2 : lvx;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("sweep_end_busy", busy, 0);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output_valid", out_valid, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_voice", out_voice, e.voice);
                check($sformatf("level_v%0d", e.voice), out, e.level);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vec[0]  = '{8'h04, 32768, 1'b1, 8'h04, 0,     0,     0};
        vec[1]  = '{8'h04, 32768, 1'b1, 8'h04, 0,     65536, 0};
        vec[2]  = '{8'h04, 32768, 1'b1, 8'h04, 0,     32768, 0};
        vec[3]  = '{8'h00, 32768, 1'b1, 8'h04, 0,     32768, 0};
        vec[4]  = '{8'h00, 32768, 1'b1, 8'h00, 0,     0,     0};
        vec[5]  = '{8'h01, 32768, 1'b1, 8'h01, 0,     0,     0};
        vec[6]  = '{8'h01, 32768, 1'b1, 8'h01, 65536, 0,     0};
        vec[7]  = '{8'h01, 32768, 1'b1, 8'h01, 32768, 0,     0};
        vec[8]  = '{8'h01, 16384, 1'b1, 8'h01, 16384, 0,     0};
        vec[9]  = '{8'h00, 16384, 1'b1, 8'h01, 16384, 0,     0};
        vec[10] = '{8'h01, 16384, 1'b0, 8'h01, 16384, 0,     0};
        vec[11] = '{8'h01, 16384, 1'b0, 8'h01, 65536, 0,     0};
        vec[12] = '{8'h00, 16384, 1'b0, 8'h01, 65536, 0,     0};
        vec[13] = '{8'h01, 16384, 1'b1, 8'h01, 0,     0,     0};
        vec[14] = '{8'h01, 16384, 1'b1, 8'h01, 65536, 0,     0};
        vec[15] = '{8'hFF, 16384, 1'b1, 8'hFF, 16384, 0,     0};
        vec[16] = '{8'hFF, 16384, 1'b1, 8'hFF, 16384, 65536, 65536};
        vec[17] = '{8'h00, 16384, 1'b1, 8'hFF, 16384, 65536, 65536};
        vec[18] = '{8'h00, 16384, 1'b1, 8'h00, 0,     0,     0};

        reset       = 1'b1;
        sample_tick = 1'b0;
        a           = 32'sh0010_0000;
        d           = 32'sh0010_0000;
        r           = 32'sh0010_0000;
        s           = 32768;
        retrig_mode = 1'b1;
        gate        = '0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_voice", out_voice, 0);
        check("rst_out", out, 0);
        check("rst_active", active, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clk);
        reset = 1'b0;

        // Sweep timing: j indexes cycle T+1+j after a tick in cycle T
        @(negedge clk);
        sample_tick = 1'b1;
        push_sweep(0, 0, 0);
        @(negedge clk);
        sample_tick = 1'b0;
        for (int j = 0; j < 10; j++) begin
            if (j > 0) @(negedge clk);
            check($sformatf("timing_busy_c%0d", j + 1), busy, (j <= 7) ? 1 : 0);
            check($sformatf("timing_valid_c%0d", j + 1), out_valid, (j >= 1 && j <= 8) ? 1 : 0);
        end

        // Overrun: tick at T+4 is dropped, tick at T+9 is accepted
        @(negedge clk);
        sample_tick = 1'b1;
        push_sweep(0, 0, 0);
        @(negedge clk);
        sample_tick = 1'b0;
        for (int j = 0; j < 11; j++) begin
            if (j > 0) @(negedge clk);
            check($sformatf("overrun_c%0d", j + 1), overrun, (j == 4) ? 1 : 0);
            if (j == 8) check("busy_before_accept", busy, 0);
            if (j == 9) check("busy_after_accept", busy, 1);
            if (j == 3) sample_tick = 1'b1;
            if (j == 4) sample_tick = 1'b0;
            if (j == 8) begin
                sample_tick = 1'b1;
                push_sweep(0, 0, 0);
            end
            if (j == 9) sample_tick = 1'b0;
        end
        wait_idle();
        @(negedge clk);
        @(negedge clk);
        check("overrun_no_extra_sweep", exp_q.size(), 0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            gate        = vec[i].gate;
            s           = vec[i].s;
            retrig_mode = vec[i].retrig;
            sample_tick = 1'b1;
            push_sweep(vec[i].lv0, vec[i].lv2, vec[i].lvx);
            @(negedge clk);
            sample_tick = 1'b0;
            wait_idle();
            @(negedge clk);
            check($sformatf("active_tick%0d", i + 1), active, vec[i].act);
        end

        // Reset mid-sweep: voice 2 is in DECAY, so a clean restart must show a fresh attack
        @(negedge clk);
        gate        = 8'h04;
        retrig_mode = 1'b1;
        s           = 32768;
        sample_tick = 1'b1;
        push_sweep(0, 0, 0);
        @(negedge clk);
        sample_tick = 1'b0;
        wait_idle();
        @(negedge clk);
        sample_tick = 1'b1;
        push_sweep(0, 65536, 0);
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_voice", out_voice, 0);
        check("midrst_out", out, 0);
        check("midrst_active", active, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        sample_tick = 1'b1;
        push_sweep(0, 0, 0);
        @(negedge clk);
        sample_tick = 1'b0;
        wait_idle();
        @(negedge clk);
        check("post_reset_active", active, 8'h04);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
